// File: rtl/lib_sram_slv_pkg.sv
// Shared types and helpers for the lib_sram_slv memory slave.
package lib_sram_slv_pkg;

  // Upper bound on the response latency; larger LAT values are clamped to it.
  localparam int unsigned LAT_MAX = 8;

  // Widest data bus the strobe merge helper handles.
  localparam int unsigned DW_MAX  = 64;
  localparam int unsigned SW_MAX  = DW_MAX / 8;

  // Replace the bytes of old_word selected by strb with the matching bytes of new_word.
  function automatic logic [DW_MAX-1:0] strb_merge(input logic [DW_MAX-1:0] old_word,
                                                   input logic [DW_MAX-1:0] new_word,
                                                   input logic [SW_MAX-1:0] strb);
    logic [DW_MAX-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < SW_MAX; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lib_sync_fifo.sv
// Synchronous FIFO with registered storage; DEPTH must be a power of two.
module lib_sync_fifo #(
  parameter int unsigned W     = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         nempty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop_ok;

  assign pop_ok = pop & nempty;
  assign nempty = (count != '0);
  assign dout   = mem[rd_ptr];

  // Storage, pointers and fill level; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lib_sram_slv.sv
// Pipelined single-port memory slave with LAT-cycle responses and up to OUTST outstanding.
// Optional address check: define LIB_SRAM_SLV_ADRCHK_EN to flag accesses above the decoded depth.
module lib_sram_slv
  import lib_sram_slv_pkg::*;
#(
  parameter int unsigned AW       = 24,
  parameter int unsigned DW       = 16,
  parameter int unsigned DEPTH_AW = 8,
  parameter int unsigned LAT      = 1,
  parameter int unsigned OUTST    = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_vld,
  output logic            req_gnt,
  input  logic            req_wr,
  input  logic [DW/8-1:0] req_strb,
  input  logic [AW-1:0]   req_adr,
  input  logic [DW-1:0]   req_dat,
  output logic            rsp_vld,
  input  logic            rsp_gnt,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err
);

  localparam int unsigned DEPTH   = 2 ** DEPTH_AW;
  localparam int unsigned CW      = $clog2(OUTST) + 1;
  localparam int unsigned RW      = DW + 1;
  localparam int unsigned LAT_EFF = (LAT < 1) ? 1 : ((LAT > LAT_MAX) ? LAT_MAX : LAT);

  typedef struct packed {
    logic          err;
    logic [DW-1:0] dat;
  } rsp_t;

  logic [DW-1:0]       mem [DEPTH];
  logic [DEPTH_AW-1:0] idx;
  logic [DW-1:0]       rd_word;
  logic [DW-1:0]       wr_word;
  logic                accept;
  logic                pop;
  logic                adr_err;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_next;
  rsp_t                rsp_new;
  rsp_t                fifo_out;
  logic                dl_vld [LAT_EFF];
  rsp_t                dl_rsp [LAT_EFF];

  assign accept  = req_vld & req_gnt;
  assign pop     = rsp_vld & rsp_gnt;
  assign idx     = req_adr[DEPTH_AW-1:0];
  assign rd_word = mem[idx];
  assign wr_word = DW'(strb_merge(DW_MAX'(rd_word), DW_MAX'(req_dat), SW_MAX'(req_strb)));

`ifdef LIB_SRAM_SLV_ADRCHK_EN
  if (DEPTH_AW < AW) begin : g_adrchk
    assign adr_err = |req_adr[AW-1:DEPTH_AW];
  end else begin : g_no_adrchk
    assign adr_err = 1'b0;
  end
`else
  assign adr_err = 1'b0;
  if (DEPTH_AW < AW) begin : g_alias
    // Upper address bits are deliberately ignored so addresses alias onto the array.
    logic unused_adr_hi;
    assign unused_adr_hi = ^req_adr[AW-1:DEPTH_AW];
  end
`endif

  // Response payload for the request at the head of the bus this cycle.
  always_comb begin
    rsp_new     = '0;
    rsp_new.err = adr_err;
    if (!adr_err) rsp_new.dat = req_wr ? wr_word : rd_word;
  end

  // Byte-merged memory write; array contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept && req_wr && !adr_err) mem[idx] <= wr_word;
  end

  // Outstanding count: accept adds, pop removes, both together leave it unchanged.
  always_comb begin
    cnt_next = cnt;
    if (accept && !pop)      cnt_next = cnt + CW'(1);
    else if (!accept && pop) cnt_next = cnt - CW'(1);
  end

  // Counter and grant flop; grant follows the count one edge later, so a pop frees a slot next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      req_gnt <= 1'b1;
    end else begin
      cnt     <= cnt_next;
      req_gnt <= (cnt_next < CW'(OUTST));
    end
  end

  // Latency delay line; the last stage pushes into the response FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < LAT_EFF; i++) begin
        dl_vld[i] <= 1'b0;
        dl_rsp[i] <= '0;
      end
    end else begin
      dl_vld[0] <= accept;
      dl_rsp[0] <= rsp_new;
      for (int unsigned i = 1; i < LAT_EFF; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_rsp[i] <= dl_rsp[i-1];
      end
    end
  end

  // Response queue; the outstanding count guarantees it never overflows.
  lib_sync_fifo #(
    .W     (RW),
    .DEPTH (OUTST)
  ) u_rsp_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .push   (dl_vld[LAT_EFF-1]),
    .din    (dl_rsp[LAT_EFF-1]),
    .pop    (pop),
    .dout   (fifo_out),
    .nempty (rsp_vld)
  );

  assign rsp_dat = fifo_out.dat;
  assign rsp_err = fifo_out.err;

endmodule

// File: tb/tb_lib_sram_slv.sv
// Directed self-checking bench for lib_sram_slv (LAT=2, OUTST=4, DEPTH_AW=8).
module tb_lib_sram_slv;

  localparam int AW    = 24;
  localparam int DW    = 16;
  localparam int DAW   = 8;
  localparam int LAT   = 2;
  localparam int OUTST = 4;

  logic          clk;
  logic          rstn;
  logic          req_vld;
  logic          req_gnt;
  logic          req_wr;
  logic [1:0]    req_strb;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_dat;
  logic          rsp_vld;
  logic          rsp_gnt;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;

  int errors = 0;
  int checks = 0;

  lib_sram_slv #(
    .AW(AW), .DW(DW), .DEPTH_AW(DAW), .LAT(LAT), .OUTST(OUTST)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_vld(req_vld), .req_gnt(req_gnt), .req_wr(req_wr), .req_strb(req_strb),
    .req_adr(req_adr), .req_dat(req_dat),
    .rsp_vld(rsp_vld), .rsp_gnt(rsp_gnt), .rsp_dat(rsp_dat), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until it is granted at a clock edge.
  task automatic send(input logic wr, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      input logic [1:0] strb);
    int n;
    n = 0;
    req_vld = 1'b1; req_wr = wr; req_adr = adr; req_dat = dat; req_strb = strb;
    while (req_gnt !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    if (req_gnt !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_gnt: req_gnt=%b after %0d cycles, required 1", req_gnt, n);
    end
    cyc();
    req_vld = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_strb = '0; req_adr = '0; req_dat = '0;
    rsp_gnt = 1'b1;
    #12;
    checks++; if (req_gnt !== 1'b1) begin errors++; $display("FAIL rst_gnt: got %b required 1", req_gnt); end
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b required 0", rsp_vld); end
    checks++; if (rsp_dat !== 16'h0000) begin errors++; $display("FAIL rst_dat: got %h required 0000", rsp_dat); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", rsp_err); end
    @(negedge clk) rstn = 1'b1;
    cyc(); cyc();
    checks++; if (req_gnt !== 1'b1) begin errors++; $display("FAIL post_rst_gnt: got %b required 1", req_gnt); end
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL post_rst_vld: got %b required 0", rsp_vld); end
  endtask

  task automatic test_write_read();
    rsp_gnt = 1'b1;
    send(1'b1, 24'h000005, 16'hBEEF, 2'b11);
    send(1'b0, 24'h000005, 16'h0000, 2'b11);
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL wr_early_vld: got %b required 0", rsp_vld); end
    cyc();
    checks++; if (rsp_vld !== 1'b1) begin errors++; $display("FAIL wr_rsp_vld: got %b required 1", rsp_vld); end
    checks++; if (rsp_dat !== 16'hBEEF) begin errors++; $display("FAIL wr_rsp_dat: got %h required BEEF", rsp_dat); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp_err: got %b required 0", rsp_err); end
    cyc();
    checks++; if (rsp_vld !== 1'b1) begin errors++; $display("FAIL rd_rsp_vld: got %b required 1", rsp_vld); end
    checks++; if (rsp_dat !== 16'hBEEF) begin errors++; $display("FAIL rd_rsp_dat: got %h required BEEF", rsp_dat); end
    cyc();
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL wr_rd_idle: got %b required 0", rsp_vld); end
  endtask

  task automatic test_strobes();
    logic          wr_v [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [DW-1:0] dat  [5] = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 16'h5555};
    logic [1:0]    strb [5] = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b01};
    logic [DW-1:0] exp  [5] = '{16'h1234, 16'hAB34, 16'hAB34, 16'hAB34, 16'hAB34};
    rsp_gnt = 1'b1;
    for (int k = 0; k < 5 + LAT; k++) begin
      if (k < 5) send(wr_v[k], 24'h000003, dat[k], strb[k]);
      else cyc();
      if (k >= LAT) begin
        checks++;
        if (rsp_vld !== 1'b1 || rsp_dat !== exp[k-LAT]) begin
          errors++;
          $display("FAIL strb_rsp%0d: got vld=%b dat=%h required vld=1 dat=%h", k - LAT, rsp_vld, rsp_dat, exp[k-LAT]);
        end
      end
    end
    cyc();
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL strb_idle: got %b required 0", rsp_vld); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    rsp_gnt = 1'b1;
    for (int k = 0; k < 16 + LAT; k++) begin
      if (k < 16) begin
        checks++; if (req_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d: got %b required 1", k, req_gnt); end
        send(1'b1, AW'(32'h10 + k), 16'hA010 + DW'(k), 2'b11);
      end else cyc();
      if (k >= LAT) begin
        exp = 16'hA010 + DW'(k - LAT);
        checks++;
        if (rsp_vld !== 1'b1 || rsp_dat !== exp) begin
          errors++;
          $display("FAIL b2b_rsp%0d: got vld=%b dat=%h required vld=1 dat=%h", k - LAT, rsp_vld, rsp_dat, exp);
        end
      end
    end
    cyc();
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b required 0", rsp_vld); end
  endtask

  task automatic test_throughput();
    logic [DW-1:0] exp;
    rsp_gnt = 1'b1;
    for (int k = 0; k < 16 + LAT; k++) begin
      if (k < 16) begin
        checks++; if (req_gnt !== 1'b1) begin errors++; $display("FAIL thr_gnt%0d: got %b required 1", k, req_gnt); end
        send(1'b0, AW'(32'h10 + k), 16'h0000, 2'b00);
      end else cyc();
      if (k < LAT) begin
        checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL thr_early%0d: got %b required 0", k, rsp_vld); end
      end else begin
        exp = 16'hA010 + DW'(k - LAT);
        checks++;
        if (rsp_vld !== 1'b1 || rsp_dat !== exp || rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL thr_rsp%0d: got vld=%b dat=%h err=%b required vld=1 dat=%h err=0", k - LAT, rsp_vld, rsp_dat, rsp_err, exp);
        end
      end
    end
    cyc();
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL thr_idle: got %b required 0", rsp_vld); end
  endtask

  task automatic test_backpressure();
    int unsigned acc;
    logic [DW-1:0] exp;
    acc = 0;
    rsp_gnt = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req_vld = 1'b1; req_wr = 1'b0; req_strb = 2'b00; req_dat = '0;
      req_adr = AW'(32'h10 + acc);
      if (req_gnt === 1'b1) acc++;
      cyc();
    end
    req_vld = 1'b0;
    checks++; if (acc != OUTST) begin errors++; $display("FAIL bp_accepted: got %0d required %0d", acc, OUTST); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (req_gnt !== 1'b0) begin errors++; $display("FAIL bp_gnt_low%0d: got %b required 0", k, req_gnt); end
      checks++;
      if (rsp_vld !== 1'b1 || rsp_dat !== 16'hA010) begin
        errors++; $display("FAIL bp_hold%0d: got vld=%b dat=%h required vld=1 dat=A010", k, rsp_vld, rsp_dat);
      end
      cyc();
    end
    rsp_gnt = 1'b1;
    for (int i = 0; i < OUTST; i++) begin
      exp = 16'hA010 + DW'(i);
      checks++;
      if (rsp_vld !== 1'b1 || rsp_dat !== exp) begin
        errors++; $display("FAIL bp_rsp%0d: got vld=%b dat=%h required vld=1 dat=%h", i, rsp_vld, rsp_dat, exp);
      end
      if (i == 0) begin
        checks++; if (req_gnt !== 1'b0) begin errors++; $display("FAIL bp_gnt_pre_pop: got %b required 0", req_gnt); end
      end
      if (i == 1) begin
        checks++; if (req_gnt !== 1'b1) begin errors++; $display("FAIL bp_gnt_post_pop: got %b required 1", req_gnt); end
      end
      cyc();
    end
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b required 0", rsp_vld); end
  endtask

  task automatic test_adrchk();
    logic [DW-1:0] exp_dat [3];
    logic          exp_err [3];
`ifdef LIB_SRAM_SLV_ADRCHK_EN
    exp_dat = '{16'h0000, 16'hBEEF, 16'h0000};
    exp_err = '{1'b1, 1'b0, 1'b1};
`else
    exp_dat = '{16'h5A5A, 16'h5A5A, 16'h5A5A};
    exp_err = '{1'b0, 1'b0, 1'b0};
`endif
    rsp_gnt = 1'b1;
    send(1'b1, 24'h000105, 16'h5A5A, 2'b11);
    send(1'b0, 24'h000005, 16'h0000, 2'b00);
    send(1'b0, 24'h000105, 16'h0000, 2'b00);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_vld !== 1'b1 || rsp_dat !== exp_dat[i] || rsp_err !== exp_err[i]) begin
        errors++;
        $display("FAIL adr_rsp%0d: got vld=%b dat=%h err=%b required vld=1 dat=%h err=%b", i, rsp_vld, rsp_dat, rsp_err, exp_dat[i], exp_err[i]);
      end
      cyc();
    end
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL adr_idle: got %b required 0", rsp_vld); end
  endtask

  task automatic test_async_reset();
    rsp_gnt = 1'b0;
    send(1'b0, 24'h000010, 16'h0000, 2'b00);
    send(1'b0, 24'h000011, 16'h0000, 2'b00);
    send(1'b0, 24'h000012, 16'h0000, 2'b00);
    checks++; if (rsp_vld !== 1'b1) begin errors++; $display("FAIL ar_pending: got %b required 1", rsp_vld); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (req_gnt !== 1'b1) begin errors++; $display("FAIL ar_gnt: got %b required 1", req_gnt); end
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL ar_vld: got %b required 0", rsp_vld); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL ar_err: got %b required 0", rsp_err); end
    checks++; if (rsp_dat !== 16'h0000) begin errors++; $display("FAIL ar_dat: got %h required 0000", rsp_dat); end
    @(negedge clk) rstn = 1'b1;
    rsp_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL ar_stale%0d: got %b required 0", k, rsp_vld); end
    end
    send(1'b0, 24'h000011, 16'h0000, 2'b00);
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL ar_new_early: got %b required 0", rsp_vld); end
    cyc();
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL ar_new_early2: got %b required 0", rsp_vld); end
    cyc();
    checks++;
    if (rsp_vld !== 1'b1 || rsp_dat !== 16'hA011) begin
      errors++; $display("FAIL ar_new_rsp: got vld=%b dat=%h required vld=1 dat=A011", rsp_vld, rsp_dat);
    end
    cyc();
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL ar_new_idle: got %b required 0", rsp_vld); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_back_to_back();
    test_throughput();
    test_backpressure();
    test_adrchk();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
